matmul_result_drain: RTL

MATMUL_RESULT_DRAIN -- requirements
Module: matmul_result_drain

---
 rtl/matmul_result_drain.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/matmul_result_drain.sv
// Drains a captured matrix-multiply result grid as a row-major valid/ready
// element stream, one element per accepted handshake, after the shifter reports done.
module matmul_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 done_i,
    input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] c_flat_i,
    input  logic [1:0]                           N_i,
    input  logic [1:0]                           M_i,
    input  logic                                 c_ready_i,
    output logic                                 c_valid_o,
    output logic [BUS_WIDTH-1:0]                 c_data_o,
    output logic [1:0]                           c_row_o,
    output logic [1:0]                           c_col_o,
    output logic                                 c_last_o,
    output logic                                 busy_o,
    output logic                                 drain_done_o,
    output logic [1:0]                           state_dbg_o
);

    localparam int FLAT_W = BUS_WIDTH * MAX_DIM * MAX_DIM;

    // Handshake: an element moves on a rising edge where c_valid_o and c_ready_i
    // are both high; while c_valid_o is high and no transfer happens, every output holds.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                done_q;
    logic                arm_q, arm_d;
    logic [FLAT_W-1:0]   snap_q, snap_d;
    logic [2:0]          n_q, n_d;
    logic [2:0]          m_q, m_d;
    logic [1:0]          row_q, row_d;
    logic [1:0]          col_q, col_d;
    logic                valid_q, valid_d;
    logic                drain_done_q, drain_done_d;

    logic                start;
    logic                xfer;
    logic                at_last_col;
    logic                at_last_row;
    logic [3:0]          elem_idx;

    // arm_q stays low after reset until done_i has been seen low, so a done
    // level still high at reset release cannot be mistaken for a fresh start.
    assign start       = done_i & ~done_q & arm_q;
    assign xfer        = valid_q & c_ready_i;
    assign at_last_col = ({1'b0, col_q} == (m_q - 3'd1));
    assign at_last_row = ({1'b0, row_q} == (n_q - 3'd1));
    assign elem_idx    = {row_q, col_q};

    always_comb begin
        state_d      = state_q;
        arm_d        = arm_q | ~done_i;
        snap_d       = snap_q;
        n_d          = n_q;
        m_d          = m_q;
        row_d        = row_q;
        col_d        = col_q;
        valid_d      = valid_q;
        drain_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = c_flat_i;
                    n_d     = {1'b0, N_i} + 3'd1;
                    m_d     = {1'b0, M_i} + 3'd1;
                    row_d   = 2'd0;
                    col_d   = 2'd0;
                    valid_d = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (at_last_row && at_last_col) begin
                        valid_d      = 1'b0;
                        drain_done_d = 1'b1;
                        row_d        = 2'd0;
                        col_d        = 2'd0;
                        state_d      = DONE;
                    end else if (at_last_col) begin
                        col_d = 2'd0;
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DONE: begin
                if (!done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            arm_q        <= 1'b0;
            snap_q       <= '0;
            n_q          <= 3'd0;
            m_q          <= 3'd0;
            row_q        <= 2'd0;
            col_q        <= 2'd0;
            valid_q      <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_i;
            arm_q        <= arm_d;
            snap_q       <= snap_d;
            n_q          <= n_d;
            m_q          <= m_d;
            row_q        <= row_d;
            col_q        <= col_d;
            valid_q      <= valid_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign c_valid_o    = valid_q;
    assign c_data_o     = snap_q[elem_idx*BUS_WIDTH +: BUS_WIDTH];
    assign c_row_o      = row_q;
    assign c_col_o      = col_q;
    assign c_last_o     = valid_q & at_last_row & at_last_col;
    assign busy_o       = (state_q == DRAIN);
    assign drain_done_o = drain_done_q;
    assign state_dbg_o  = state_q;

endmodule
